// File: rtl/shift_sequencer.sv
// shift_sequencer: iterative SLL/SRL/SRA shifter with a start/busy/done handshake;
// define SHIFT_SEQ_ROTR_EN to make op=11 rotate right instead of shift left.
module shift_sequencer #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [4:0]  shamt,
  input  logic [31:0] data_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [4:0] STEP_W = 5'(STEP);
  state_t      state;
  logic [1:0]  op_q;
  logic [4:0]  rem, s, rem_nx;
  logic [31:0] work, shifted;
  logic        accept;
`ifdef SHIFT_SEQ_ROTR_EN
  logic [63:0] rot;
`endif
  assign accept = start && state != SHIFT;
  assign result = work;
  always_comb begin
    s = rem < STEP_W ? rem : STEP_W;
    rem_nx = rem - s;
`ifdef SHIFT_SEQ_ROTR_EN
    rot = {work, work} >> s;
    shifted = op_q == 2'b01 ? work >> s :
              op_q == 2'b10 ? $unsigned($signed(work) >>> s) :
              op_q == 2'b11 ? rot[31:0] : work << s;
`else
    shifted = op_q == 2'b01 ? work >> s :
              op_q == 2'b10 ? $unsigned($signed(work) >>> s) : work << s;
`endif
  end
  // busy/done are computed from the next state so they stay registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= 2'b00;
      rem   <= 5'd0;
      work  <= 32'h0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (accept) begin
      op_q  <= op;
      work  <= data_in;
      rem   <= shamt;
      state <= shamt == 5'd0 ? DONE : SHIFT;
      busy  <= shamt != 5'd0;
      done  <= shamt == 5'd0;
    end else if (state == SHIFT) begin
      work  <= shifted;
      rem   <= rem_nx;
      state <= rem_nx == 5'd0 ? DONE : SHIFT;
      busy  <= rem_nx != 5'd0;
      done  <= rem_nx == 5'd0;
    end else begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: randomized scoreboard bench for shift_sequencer.
module tb_shift_sequencer;
  localparam int STEP = 4;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [4:0]  shamt = 5'd0;
  logic [31:0] data_in = 32'h0;
  logic        busy, done;
  logic [31:0] result;
  typedef struct { logic [31:0] res; int cyc; } exp_t;
  exp_t q[$];
  int cyc = 0, cur_a = -100, cur_n = 0, checks = 0, errors = 0;
  logic [31:0] last_exp = 32'h0;

  shift_sequencer #(.STEP(STEP)) dut (.clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .shamt(shamt), .data_in(data_in), .busy(busy), .done(done), .result(result));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [4:0] sh, input logic [31:0] d);
    int n = int'(sh);
    if (n == 0) return d;
    case (o)
      2'b01: return d >> n;
      2'b10: return $unsigned($signed(d) >>> n);
`ifdef SHIFT_SEQ_ROTR_EN
      2'b11: return (d >> n) | (d << (32 - n));
`endif
      default: return d << n;
    endcase
  endfunction

  task automatic req(input logic [1:0] o, input logic [4:0] sh, input logic [31:0] d);
    int n = (int'(sh) + STEP - 1) / STEP;
    @(negedge clk);
    start = 1'b1; op = o; shamt = sh; data_in = d;
    @(posedge clk); #1;
    q.push_back('{model(o, sh, d), cyc + n});
    cur_a = cyc; cur_n = n;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start = $urandom_range(0, 3) == 0;
      op = 2'($urandom); shamt = 5'($urandom); data_in = $urandom;
    end
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    start = 1'b0;
    repeat (k) @(posedge clk);
  endtask

  always @(negedge clk) if (rst_n) begin
    exp_t e;
    check("busy", {31'b0, busy}, {31'b0, cyc >= cur_a && cyc < cur_a + cur_n});
    if (done) begin
      if (q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        check("result", result, e.res);
        check("latency", cyc, e.cyc);
        last_exp = e.res;
      end
    end else if (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      check("missing_done", 32'd0, 32'd1);
    end else if (cyc > cur_a + cur_n) check("result_hold", result, last_exp);
  end

  initial begin
    int t;
    #2;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'h0);
    #10 rst_n = 1'b1;
    idle(5);
    req(2'b00, 5'd2, 32'h0000_0001);
    req(2'b00, 5'd31, 32'h0000_0001);
    idle(2);
    req(2'b10, 5'd31, 32'h8000_0000);
    req(2'b01, 5'd31, 32'h8000_0000);
    idle(1);
    req(2'b00, 5'd0, 32'hDEAD_BEEF);
    req(2'b01, 5'd4, 32'hDEAD_BEEF);
    idle(3);
    req(2'b11, 5'd4, 32'h0000_0001);
    idle(3);
    @(negedge clk);
    start = 1'b1; op = 2'b00; shamt = 5'd31; data_in = 32'h1;
    @(posedge clk); #1;
    cur_a = cyc; cur_n = 8;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    cur_a = -100; cur_n = 0; last_exp = 32'h0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_result", result, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(12);
    repeat (150) begin
      req(2'($urandom), 5'($urandom), $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3));
    end
    idle(2);
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 32'd0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift controller for the MIPS datapath: accepts a shift request (SLL/SRL/SRA, optional ROTR) with a 5-bit amount and iterates a fixed-stride shifter until the full amount is applied. It exposes a start/busy/done handshake so the control unit can stall the PC and register write-back while a variable shift is in flight. The block replaces a 32-bit barrel shifter with a small iterative datapath plus FSM.

## Interface

- `STEP`, default 4: bits shifted per iteration; legal values 1, 2, 4, 8, 16.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request strobe; sampled only when the block accepts (see Operation).
- `op`  input  2  00 = SLL, 01 = SRL, 10 = SRA, 11 = ROTR (see Configuration).
- `shamt`  input  5  shift amount, 0–31.
- `data_in`  input  32  operand.
- `busy`  output  1  high while a request is in progress; drives the pipeline stall.
- `done`  output  1  one-cycle completion pulse.
- `result`  output  32  shifted value; valid when `done` = 1, then held.

## Operation

- FSM states: IDLE, SHIFT, DONE.
- Accept condition: `start` = 1 in IDLE or DONE. On acceptance, latch `op`, `data_in` into the working register, and `shamt` into the remaining-count register.
- Transition on acceptance: to DONE if `shamt` = 0, else to SHIFT.
- SHIFT state, each cycle:
  - Shift the working register by `s` = min(STEP, remaining), then `remaining -= s`.
  - SLL fills with 0. SRL fills with 0. SRA fills with bit 31 of the working register at that cycle.
  - Go to DONE when the new remaining value is 0, else stay in SHIFT.
- DONE state: `done` = 1 for exactly this cycle. Next state is SHIFT or DONE if a new request is accepted, else IDLE.
- `start` in SHIFT is ignored; the request is not queued.
- `busy` = 1 in SHIFT. It is also 1 in DONE only when `start` is accepted in that DONE cycle; otherwise `busy` = 0.
- `result` is the working register. It must equal `data_in` shifted by `shamt` when `done` = 1, and it holds that value until the next acceptance.
- Arithmetic: `shamt` is 5-bit unsigned, so no value ≥ 32 is possible. The remaining count uses 5 bits and never underflows.

## Timing

- Reset values:
  - State = IDLE.
  - `busy` = 0, `done` = 0, `result` = 32'h0000_0000.
  - Remaining count = 0.
- Latency from the accepting edge to `done` high: N + 1 cycles, where N = ceil(`shamt`/STEP).
  - `shamt` = 0 → `done` 1 cycle after acceptance.
  - STEP = 4, `shamt` = 31 → N = 8, so `done` 9 cycles after acceptance.
- Back-to-back requests: `start` held high through the DONE cycle is accepted there, with no IDLE bubble.
- Reset asserted mid-operation: immediately return to IDLE with reset values. A `done` pulse must not be emitted for the aborted request.
- Outputs are registered; there is no combinational path from the inputs to `busy`, `done` or `result`.

## Configuration

- `SHIFT_SEQ_ROTR_EN` defined: `op` = 11 performs rotate right. Bits shifted out of bit 0 re-enter at bit 31 each iteration, and latency is the same as the other ops.
- `SHIFT_SEQ_ROTR_EN` undefined: `op` = 11 is decoded as SLL. No rotate logic is synthesized.

## Test plan

- Reset: `rst_n` = 0 → `busy` = 0, `done` = 0, `result` = 0. Release, with `start` = 0 for 5 cycles → all outputs unchanged.
- SLL, STEP = 4: `data_in` = 32'h0000_0001, `shamt` = 2 → `done` 2 cycles after acceptance, `result` = 32'h0000_0004. Then `data_in` = 32'h0000_0001, `shamt` = 31 → `done` after 9 cycles, `result` = 32'h8000_0000.
- SRA vs SRL: `data_in` = 32'h8000_0000, `shamt` = 31 → SRA gives 32'hFFFF_FFFF and SRL gives 32'h0000_0001, each after 9 cycles.
- Zero and back-to-back: `shamt` = 0 on 32'hDEAD_BEEF → `done` after 1 cycle with `result` = 32'hDEAD_BEEF. Hold `start` for a second request (SRL 4) → `done` 2 cycles later, `result` = 32'h0DEA_DBEE. `busy` stays high across the DONE boundary.
- Busy/abort: assert `start` again while in SHIFT → ignored, and `result` matches the first request. Drop `rst_n` at cycle 3 of an SLL 31 → IDLE, no `done` pulse.
- ROTR (macro defined): `data_in` = 32'h0000_0001, `shamt` = 4 → `result` = 32'h1000_0000. With the macro undefined, the same stimulus gives 32'h0000_0010.
